// File: rtl/nn_isa_pkg.sv
// Instruction-set definitions shared by the nn control unit and its issuers.
// Field positions and the NOP word live here so both sides agree on the layout.
package nn_isa_pkg;

  localparam int INSTR_W          = 38;
  localparam int DATA_LSB         = 0;
  localparam int DATA_W           = 16;
  localparam int FIELD_ADDR_LSB   = 16;
  localparam int FIELD_ADDR_W     = 2;
  localparam int LOAD_BIAS_BIT    = 18;
  localparam int LOAD_WEIGHTS_BIT = 19;
  localparam int LOAD_INPUTS_BIT  = 20;
  localparam int NN_START_BIT     = 21;
  localparam int ACT_LSB          = 22;
  localparam int ACT_W            = 2;
  localparam int RSVD_LSB         = 24;
  localparam int RSVD_W           = 14;

  typedef struct packed {
    logic [RSVD_W-1:0]       reserved;
    logic [ACT_W-1:0]        activation_datapath;
    logic                    nn_start;
    logic                    load_inputs;
    logic                    load_weights;
    logic                    load_bias;
    logic [FIELD_ADDR_W-1:0] address;
    logic [DATA_W-1:0]       input_data_in;
  } instr_t;

  localparam instr_t INSTR_NOP = instr_t'(38'd0);

endpackage

// File: rtl/instr_mem.sv
// Program store for the sequencer: one clocked write port and one
// combinational read port, contents deliberately left unreset.
module instr_mem #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 46,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Capture a program word on the clock edge when the write is qualified.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues a preloaded program onto the nn instruction bus, holding each word
// for its programmed number of extra cycles; drives NOP when not running.
module instr_sequencer
  import nn_isa_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_wr_en,
  input  logic [ADDR_W-1:0]  prog_wr_addr,
  input  logic [INSTR_W-1:0] prog_wr_instr,
  input  logic [HOLD_W-1:0]  prog_wr_hold,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  input  logic               abort,
  output logic [INSTR_W-1:0] instruction,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  pc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam int                ENTRY_W   = INSTR_W + HOLD_W;
  localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_ZERO   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W - 1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W - 1){1'b0}}, 1'b1};

  seq_state_t          state_r, state_s;
  logic [ADDR_W-1:0]   pc_r, pc_s;
  logic [ADDR_W-1:0]   last_pc_r, last_pc_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_s;
  instr_t              instr_r, instr_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;

  logic                wr_en_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic [ENTRY_W-1:0]  rd_entry_s;
  instr_t              rd_instr_s;
  logic [HOLD_W-1:0]   rd_hold_s;
  logic [ADDR_W:0]     len_clamped_s;
  logic [ADDR_W:0]     len_last_s;

  // The program is frozen while a run is in flight.
  assign wr_en_s = prog_wr_en & (state_r != ST_RUN) & ({1'b0, prog_wr_addr} < DEPTH_LEN);

  instr_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (ENTRY_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (prog_wr_addr),
    .wr_data ({prog_wr_hold, prog_wr_instr}),
    .rd_addr (rd_addr_s),
    .rd_data (rd_entry_s)
  );

  assign rd_instr_s    = instr_t'(rd_entry_s[INSTR_W-1:0]);
  assign rd_hold_s     = rd_entry_s[ENTRY_W-1:INSTR_W];
  assign len_clamped_s = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
  assign len_last_s    = len_clamped_s - LEN_ONE;

  // Next-state and next-output logic; outputs default to the idle NOP values.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    last_pc_s  = last_pc_r;
    hold_cnt_s = hold_cnt_r;
    instr_s    = INSTR_NOP;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    rd_addr_s  = PC_ZERO;
    case (state_r)
      ST_IDLE: begin
        pc_s = PC_ZERO;
        if (start) begin
          if (len_clamped_s == LEN_ZERO) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            state_s    = ST_RUN;
            last_pc_s  = len_last_s[ADDR_W-1:0];
            instr_s    = rd_instr_s;
            hold_cnt_s = rd_hold_s;
            busy_s     = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Prefetch the following entry so a zero-gap handover is possible.
        rd_addr_s = pc_r + PC_ONE;
        if (abort) begin
          state_s = ST_IDLE;
          pc_s    = PC_ZERO;
        end else if (hold_cnt_r != HOLD_ZERO) begin
          hold_cnt_s = hold_cnt_r - HOLD_ONE;
          instr_s    = instr_r;
          busy_s     = 1'b1;
        end else if (pc_r == last_pc_r) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else begin
          pc_s       = pc_r + PC_ONE;
          instr_s    = rd_instr_s;
          hold_cnt_s = rd_hold_s;
          busy_s     = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        pc_s    = PC_ZERO;
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = PC_ZERO;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      pc_r       <= PC_ZERO;
      last_pc_r  <= PC_ZERO;
      hold_cnt_r <= HOLD_ZERO;
      instr_r    <= INSTR_NOP;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      last_pc_r  <= last_pc_s;
      hold_cnt_r <= hold_cnt_s;
      instr_r    <= instr_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign instruction = instr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign pc          = pc_r;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Issuer side of the 38-bit `instruction` bus consumed by the nn control unit. A host preloads a short program into a local instruction memory and then pulses `start`. The block drives one instruction word per slot onto `instruction`, holds each word for a programmed number of cycles, and drives the all-zero NOP word whenever it is not running. It sits between the host/testbench and `nn`, replacing hand-driven instruction stimulus.

## Interface
- `DEPTH`, 16: number of program entries.
- `HOLD_W`, 8: width of the per-entry hold count.
- `ADDR_W`, `$clog2(DEPTH)`: program address width.

- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `prog_wr_en`  in  1  program write strobe.
- `prog_wr_addr`  in  ADDR_W  program write address.
- `prog_wr_instr`  in  38  instruction word to store.
- `prog_wr_hold`  in  HOLD_W  extra cycles to hold this word.
- `prog_len`  in  ADDR_W+1  number of entries to run; sampled on `start`.
- `start`  in  1  launch pulse.
- `abort`  in  1  stop the run immediately.
- `instruction`  out  38  word driven to `nn`.
- `busy`  out  1  a run is in progress.
- `done`  out  1  one-cycle pulse at normal completion.
- `pc`  out  ADDR_W  index of the entry currently driven.

## Operation
- Instruction field layout:
  - [15:0] `input_data_in`
  - [17:16] `address`
  - [18] `load_bias`
  - [19] `load_weights`
  - [20] `load_inputs`
  - [21] `nn_start`
  - [23:22] `activation_datapath`
  - [37:24] reserved, must be 0
- The block does not modify or check the stored words; it passes them through verbatim.
- NOP is 38'b0.
- States:
  - IDLE: `instruction`=NOP, `busy`=0.
    - `start` with `prog_len`=0 → DONE.
    - `start` with `prog_len`≥1 → RUN: latch `prog_len`, load entry 0, set hold counter to its hold value.
  - RUN: drives the current entry, `busy`=1.
    - `abort` → IDLE. No `done` pulse.
    - Hold counter ≠ 0: decrement it.
    - Hold counter = 0 and pc = len−1 → DONE.
    - Otherwise: pc+1, load that entry and its hold value.
  - DONE: one cycle. `instruction`=NOP, `done`=1, `busy`=0. Then → IDLE.
- Program writes are accepted in IDLE and DONE and ignored in RUN.
- Writes to addresses ≥ DEPTH are ignored.
- `prog_len` > DEPTH is clamped to DEPTH.
- `start` is ignored in RUN and DONE.
- `abort` outside RUN has no effect.
- `abort` and `start` in the same IDLE cycle: `start` wins.

## Timing
- Reset values: `instruction`=0, `busy`=0, `done`=0, `pc`=0, state=IDLE. Program memory contents are not reset.
- Reset mid-run returns the block to the reset values on the next edge.
- All outputs are registered.
- Entry 0 appears on `instruction` the cycle after `start` is sampled.
- Each entry is visible for hold+1 consecutive cycles.
- The next entry follows with no gap.
- DONE occupies the cycle immediately after the last entry's final cycle.
- A run of L entries with holds h_i spans Σ(h_i+1) RUN cycles plus 1 DONE cycle.
- Program memory uses asynchronous read and is written on the clock edge.
- A write and `start` in the same cycle: the write to address 0 is not seen by that run; entry 0 issues its old contents.
- After `abort`, `instruction` is NOP on the next cycle.
- `pc` is held during hold cycles.
- `pc` returns to 0 on entry to IDLE.

## Structure
- Shared package `nn_isa_pkg`:
  - `instr_t` (38-bit packed struct carrying the field layout above).
  - `INSTR_NOP`.
  - Field position constants.
  - Used by both this block and the control unit.
- State enum `seq_state_t` (IDLE/RUN/DONE) is local to this block.
- One sub-module, `instr_mem`: DEPTH × (38+HOLD_W) register file, one write port, one asynchronous read port.

## Test plan
- **Basic run.** Write 3 entries, all holds 0: entry 0 = `nn_start`+`load_inputs`, addr=01, data=0x0100; entries 1 and 2 follow. Set `prog_len`=3 and pulse `start` at cycle T.
  - → Words appear at T+1, T+2, T+3.
  - → `done`=1 and NOP at T+4.
  - → `busy`=1 exactly T+1..T+3.
- **Hold counts.** Entry 0 hold=2, entry 1 hold=0, `prog_len`=2.
  - → Entry 0 is driven for 3 cycles, entry 1 for 1 cycle, then `done`.
  - → `pc` reads 0,0,0,1.
- **Abort.** 4-entry program, `abort` on the 2nd RUN cycle.
  - → NOP on the next cycle, `busy`=0, no `done` pulse.
  - → A subsequent `start` reruns from entry 0.
- **Edge cases.**
  - `prog_len`=0 → `done` pulses the cycle after `start`; NOP throughout.
  - `prog_len`=20 with DEPTH=16 → 16 entries issued.
- **Ignored inputs.** `start` and a program write issued mid-run.
  - → Run is unaffected.
  - → Memory readback after the run shows the old value.
- **Reset and same-cycle write.** Assert `rst` mid-hold → all outputs 0 next cycle. Same-cycle write to address 0 with `start` → old entry 0 issued.
